// File: rtl/bitmap_shadow.sv
// Double-buffered 2-bit playfield: the writer edits a work array, and a commit copies it
// to the display array when the reader wraps from the last row to row 0, or on timeout.
module bitmap_shadow #(
  parameter int AREA_ROW     = 32,
  parameter int AREA_COL     = 16,
  parameter int ROW_ADDR_W   = 5,
  parameter int COL_ADDR_W   = 4,
  parameter int SWAP_TIMEOUT = 1_048_576
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wr_en,
  input  logic [ROW_ADDR_W-1:0]   wr_row,
  input  logic [COL_ADDR_W-1:0]   wr_col,
  input  logic [1:0]              wr_val,
  input  logic                    clr_en,
  input  logic                    commit,
  input  logic [ROW_ADDR_W-1:0]   chk_row,
  input  logic [COL_ADDR_W-1:0]   chk_col,
  output logic [1:0]              chk_val,
  output logic                    busy,
  output logic                    swap_pulse,
  input  logic [ROW_ADDR_W-1:0]   bitmap_row,
  output logic [AREA_COL*2-1:0]   bitmap_data,
  output logic [1:0]              dbg_state
);

  localparam int TMO_W = (SWAP_TIMEOUT > 1) ? $clog2(SWAP_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, PEND = 2'd2} state_t;
  typedef logic [AREA_COL-1:0][1:0] row_t;

  state_t                state_q, state_d;
  row_t                  work_q [AREA_ROW];
  row_t                  disp_q [AREA_ROW];
  logic [ROW_ADDR_W-1:0] row_d;
  logic [ROW_ADDR_W-1:0] row_cnt_q;
  logic [TMO_W-1:0]      tmo_q;
  logic                  swap_pulse_q;

  logic wr_do, clr_row_do, swap_do;
  logic chk_row_ok, chk_col_ok, wr_row_ok, wr_col_ok, rd_row_ok;
  logic reader_wrap, tmo_done, row_last;
  row_t disp_row;

  // Range checks collapse to constants when the address width exactly covers the array.
  if (AREA_ROW >= (1 << ROW_ADDR_W)) begin : g_row_full
    assign chk_row_ok = 1'b1;
    assign wr_row_ok  = 1'b1;
    assign rd_row_ok  = 1'b1;
  end else begin : g_row_part
    assign chk_row_ok = (chk_row    < ROW_ADDR_W'(AREA_ROW));
    assign wr_row_ok  = (wr_row     < ROW_ADDR_W'(AREA_ROW));
    assign rd_row_ok  = (bitmap_row < ROW_ADDR_W'(AREA_ROW));
  end

  if (AREA_COL >= (1 << COL_ADDR_W)) begin : g_col_full
    assign chk_col_ok = 1'b1;
    assign wr_col_ok  = 1'b1;
  end else begin : g_col_part
    assign chk_col_ok = (chk_col < COL_ADDR_W'(AREA_COL));
    assign wr_col_ok  = (wr_col  < COL_ADDR_W'(AREA_COL));
  end

  assign reader_wrap = (row_d == ROW_ADDR_W'(AREA_ROW - 1)) && (bitmap_row == '0);
  assign tmo_done    = (tmo_q == TMO_W'(SWAP_TIMEOUT - 1));
  assign row_last    = (row_cnt_q == ROW_ADDR_W'(AREA_ROW - 1));

  // Command handshake: wr_en/clr_en/commit are single-cycle requests accepted only while
  // busy is low; while busy is high they are dropped, so the writer must gate on busy.
  always_comb begin
    state_d    = state_q;
    wr_do      = 1'b0;
    clr_row_do = 1'b0;
    swap_do    = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_en)      state_d = CLEAR;
        else if (commit) state_d = PEND;
        else if (wr_en && wr_row_ok && wr_col_ok) wr_do = 1'b1;
      end
      CLEAR: begin
        clr_row_do = 1'b1;
        if (row_last) state_d = IDLE;
      end
      PEND: begin
        if (reader_wrap || tmo_done) begin
          swap_do = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      row_d        <= '0;
      row_cnt_q    <= '0;
      tmo_q        <= '0;
      swap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_d        <= bitmap_row;
      row_cnt_q    <= (state_q == CLEAR && !row_last) ? row_cnt_q + 1'b1 : '0;
      tmo_q        <= (state_q == PEND) ? tmo_q + 1'b1 : '0;
      swap_pulse_q <= swap_do;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < AREA_ROW; r++) begin
        work_q[r] <= '0;
        disp_q[r] <= '0;
      end
    end else begin
      if (clr_row_do)  work_q[row_cnt_q] <= '0;
      else if (wr_do)  work_q[wr_row][wr_col] <= wr_val;
      if (swap_do) begin
        for (int r = 0; r < AREA_ROW; r++) disp_q[r] <= work_q[r];
      end
    end
  end

  assign chk_val = (chk_row_ok && chk_col_ok) ? work_q[chk_row][chk_col] : 2'b00;

  // Display row is split into two bit-planes: value[0] in the low half, value[1] in the high.
  always_comb begin
    bitmap_data = '0;
    disp_row    = rd_row_ok ? disp_q[bitmap_row] : '0;
    for (int c = 0; c < AREA_COL; c++) begin
      bitmap_data[c]            = disp_row[c][0];
      bitmap_data[c + AREA_COL] = disp_row[c][1];
    end
  end

  assign busy       = (state_q != IDLE);
  assign swap_pulse = swap_pulse_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bitmap_shadow.sv
// Directed bench for bitmap_shadow: write/probe, wrap and timeout commits, clear,
// command priority and reset abort, with hand-computed expected values.
module tb_bitmap_shadow;

  logic        clk;
  logic        rstn;
  logic        wr_en;
  logic [4:0]  wr_row;
  logic [3:0]  wr_col;
  logic [1:0]  wr_val;
  logic        clr_en;
  logic        commit;
  logic [4:0]  chk_row;
  logic [3:0]  chk_col;
  logic [1:0]  chk_val;
  logic        busy;
  logic        swap_pulse;
  logic [4:0]  bitmap_row;
  logic [31:0] bitmap_data;
  logic [1:0]  dbg_state;

  int checks;
  int failures;
  int n;
  int bad;
  logic seen_swap;
  logic [31:0] exp_q[$];
  logic [31:0] exp_row;

  bitmap_shadow #(
    .AREA_ROW    (32),
    .AREA_COL    (16),
    .ROW_ADDR_W  (5),
    .COL_ADDR_W  (4),
    .SWAP_TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_val     (wr_val),
    .clr_en     (clr_en),
    .commit     (commit),
    .chk_row    (chk_row),
    .chk_col    (chk_col),
    .chk_val    (chk_val),
    .busy       (busy),
    .swap_pulse (swap_pulse),
    .bitmap_row (bitmap_row),
    .bitmap_data(bitmap_data),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cell(input int r, input int c, input logic [1:0] v);
    wr_en  = 1'b1;
    wr_row = 5'(r);
    wr_col = 4'(c);
    wr_val = v;
    step();
    wr_en  = 1'b0;
  endtask

  task automatic probe(input string tag, input int r, input int c, input logic [1:0] v);
    chk_row = 5'(r);
    chk_col = 4'(c);
    #1;
    check_eq(tag, {30'd0, chk_val}, {30'd0, v});
  endtask

  // scoreboard: expected display rows queued, then drained against bitmap_data
  task automatic check_display(input string tag);
    for (int r = 0; r < 32; r++) begin
      exp_row = 32'd0;
      if (r == 3)  exp_row = 32'h0020_0000;
      if (r == 31) exp_row = 32'h0000_8000;
      exp_q.push_back(exp_row);
    end
    bad = 0;
    for (int r = 0; r < 32; r++) begin
      bitmap_row = 5'(r);
      #1;
      exp_row = exp_q.pop_front();
      if (bitmap_data !== exp_row) bad++;
    end
    check_eq(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rstn = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_val = '0;
    clr_en = 1'b0; commit = 1'b0; chk_row = '0; chk_col = '0; bitmap_row = '0;
    step(); step();
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_swap", {31'd0, swap_pulse}, 32'd0);
    check_eq("rst_bitmap", bitmap_data, 32'd0);
    check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
    rstn = 1'b1;
    step();

    // write then probe
    write_cell(3, 5, 2'b10);
    probe("probe_3_5", 3, 5, 2'b10);
    write_cell(31, 15, 2'b01);
    probe("probe_31_15", 31, 15, 2'b01);
    probe("probe_3_4", 3, 4, 2'b00);
    bitmap_row = 5'd3;
    #1;
    check_eq("display_pre_commit", bitmap_data, 32'd0);

    // commit released by a reader wrap 31 -> 0
    commit = 1'b1;
    step();
    commit = 1'b0;
    check_eq("pend_busy", {31'd0, busy}, 32'd1);
    check_eq("pend_state", {30'd0, dbg_state}, 32'd2);
    bitmap_row = 5'd31;
    step();
    check_eq("pend_no_swap", {31'd0, swap_pulse}, 32'd0);
    bitmap_row = 5'd0;
    step();
    check_eq("wrap_swap", {31'd0, swap_pulse}, 32'd1);
    check_eq("wrap_busy", {31'd0, busy}, 32'd0);
    bitmap_row = 5'd3;
    step();
    check_eq("swap_one_cycle", {31'd0, swap_pulse}, 32'd0);
    check_eq("display_row3", bitmap_data, 32'h0020_0000);
    check_display("display_after_wrap");
    probe("work_kept", 3, 5, 2'b10);

    // commit released by timeout with the reader parked on row 7
    bitmap_row = 5'd7;
    step();
    commit = 1'b1;
    step();
    commit = 1'b0;
    n = 0;
    while (!swap_pulse && n < 40) begin
      step();
      n++;
    end
    check_eq("timeout_cycles", 32'(n), 32'd16);
    check_eq("timeout_busy", {31'd0, busy}, 32'd0);
    step();

    // clear: fill with 2'b11, clear, attempt a write during CLEAR
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 16; c++)
        write_cell(r, c, 2'b11);
    probe("fill_check", 17, 9, 2'b11);
    clr_en = 1'b1;
    step();
    clr_en = 1'b0;
    wr_en = 1'b1; wr_row = 5'd0; wr_col = 4'd0; wr_val = 2'b01;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    wr_en = 1'b0;
    check_eq("clear_busy_cycles", 32'(n), 32'd32);
    bad = 0;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 16; c++) begin
        chk_row = 5'(r);
        chk_col = 4'(c);
        #1;
        if (chk_val !== 2'b00) bad++;
      end
    check_eq("clear_all_zero", 32'(bad), 32'd0);
    check_display("display_after_clear");

    // priority: clr_en beats commit beats wr_en
    clr_en = 1'b1; commit = 1'b1;
    wr_en = 1'b1; wr_row = 5'd2; wr_col = 4'd2; wr_val = 2'b11;
    step();
    clr_en = 1'b0; commit = 1'b0; wr_en = 1'b0;
    check_eq("prio_clear_state", {30'd0, dbg_state}, 32'd1);
    n = 0; seen_swap = 1'b0;
    while (busy && n < 100) begin
      step();
      n++;
      if (swap_pulse) seen_swap = 1'b1;
    end
    check_eq("prio_no_swap", {31'd0, seen_swap}, 32'd0);
    probe("prio_write_dropped", 2, 2, 2'b00);

    bitmap_row = 5'd3;
    commit = 1'b1;
    wr_en = 1'b1; wr_row = 5'd4; wr_col = 4'd1; wr_val = 2'b01;
    step();
    commit = 1'b0;
    check_eq("prio_pend_state", {30'd0, dbg_state}, 32'd2);
    probe("commit_beats_write", 4, 1, 2'b00);
    step();
    wr_en = 1'b0;
    probe("pend_write_ignored", 4, 1, 2'b00);

    // reset in PEND aborts immediately
    rstn = 1'b0;
    #1;
    check_eq("rst_pend_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_pend_bitmap", bitmap_data, 32'd0);
    check_eq("rst_pend_swap", {31'd0, swap_pulse}, 32'd0);
    step();
    rstn = 1'b1;
    step();
    check_eq("post_rst_state", {30'd0, dbg_state}, 32'd0);
    check_eq("post_rst_swap", {31'd0, swap_pulse}, 32'd0);
    probe("post_rst_work", 3, 5, 2'b00);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
